// File: rtl/dot_matrix_scanner_pkg.sv
// rtl/dot_matrix_scanner_pkg.sv - shared constants and FSM state encoding for the dot matrix scanner
package dot_matrix_scanner_pkg;

  localparam int N_ROWS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_FETCH = 2'd2,
    ST_SHOW  = 2'd3
  } state_e;

endpackage

// File: rtl/dot_matrix_scanner.sv
// rtl/dot_matrix_scanner.sv - 16-row LED dot matrix scanner with blanking, column fetch and frame pulse
module dot_matrix_scanner
  import dot_matrix_scanner_pkg::*;
#(
  parameter int ROW_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] col_in,
  output logic [3:0]  row_bin,
  output logic [15:0] row,
  output logic [15:0] col,
  output logic        frame_done
);

  localparam int MAX_CYCLES = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_e        state_q, state_d;
  logic [3:0]    index_q, index_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   col_q, col_d;
  logic          frame_q, frame_d;
  logic          last_row;

  assign last_row = (index_q == 4'(N_ROWS - 1));

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    frame_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        index_d = 4'd0;
        cnt_d   = '0;
        col_d   = 16'd0;
        if (en) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FETCH: begin
        col_d   = col_in;
        cnt_d   = '0;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (cnt_q == CW'(ROW_CYCLES - 1)) begin
          cnt_d   = '0;
          index_d = last_row ? 4'd0 : index_q + 4'd1;
          frame_d = last_row;
          state_d = ST_BLANK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Dropping enable aborts the row at once and suppresses any pending frame pulse.
    if (state_q != ST_IDLE && !en) begin
      state_d = ST_IDLE;
      index_d = 4'd0;
      cnt_d   = '0;
      col_d   = 16'd0;
      frame_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      index_q <= 4'd0;
      cnt_q   <= '0;
      col_q   <= 16'd0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      frame_q <= frame_d;
    end
  end

  // Row and column drive are both gated by SHOW so they can never overlap a row change.
  assign row_bin    = index_q;
  assign row        = (state_q == ST_SHOW) ? (16'd1 << index_q) : 16'd0;
  assign col        = (state_q == ST_SHOW) ? col_q : 16'd0;
  assign frame_done = frame_q;

endmodule
